// File: rtl/tpu_ctrl.sv
// rtl/tpu_ctrl.sv - TPU execute-side matrix multiply-accumulate responder
module tpu_ctrl #(
  parameter int DIM    = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wren_A_i,
  input  logic              wren_B_i,
  input  logic              wren_C_i,
  input  logic              start_i,
  input  logic [4:0]        row_i,
  input  logic [4:0]        col_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              stall_o
);

  localparam int         NEL   = DIM * DIM;
  localparam int         IW    = (NEL > 1) ? $clog2(NEL) : 1;
  localparam logic [5:0] DIM_L = 6'(DIM);
  localparam logic [4:0] LAST  = 5'(DIM - 1);

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  state_t            state;
  logic [4:0]        i, j, k;
  logic [DATA_W-1:0] a_m [NEL];
  logic [DATA_W-1:0] b_m [NEL];
  logic [DATA_W-1:0] c_m [NEL];

  // Matrices are stored row-major in flat arrays.
  function automatic logic [IW-1:0] idx(input logic [4:0] r, input logic [4:0] c);
    return IW'(32'(r) * 32'(DIM) + 32'(c));
  endfunction

  function automatic logic in_range(input logic [4:0] r, input logic [4:0] c);
    return ({1'b0, r} < DIM_L) && ({1'b0, c} < DIM_L);
  endfunction

  // Any command arriving while an operation is in flight holds the ID/EX register.
  assign stall_o = busy_o & (start_i | wren_A_i | wren_B_i | wren_C_i);

  // Control FSM, i-j-k loop counters and matrix storage updates.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= IDLE;
      i      <= '0;
      j      <= '0;
      k      <= '0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      for (int n = 0; n < NEL; n++) begin
        a_m[n] <= '0;
        b_m[n] <= '0;
        c_m[n] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          // Writes land before a same-cycle start so the MAC sees the new value.
          if (in_range(row_i, col_i)) begin
            if (wren_A_i) a_m[idx(row_i, col_i)] <= data_i;
            if (wren_B_i) b_m[idx(row_i, col_i)] <= data_i;
            if (wren_C_i) c_m[idx(row_i, col_i)] <= data_i;
          end
          if (start_i) begin
            state  <= MAC;
            busy_o <= 1'b1;
            i      <= '0;
            j      <= '0;
            k      <= '0;
          end
        end
        MAC: begin
          // Low DATA_W bits of product and sum: identical for signed and unsigned.
          c_m[idx(i, j)] <= c_m[idx(i, j)] + a_m[idx(i, k)] * b_m[idx(k, j)];
          if (k == LAST) begin
            k <= '0;
            if (j == LAST) begin
              j <= '0;
              if (i == LAST) begin
                i      <= '0;
                state  <= DONE;
                done_o <= 1'b1;
              end else begin
                i <= i + 5'd1;
              end
            end else begin
              j <= j + 5'd1;
            end
          end else begin
            k <= k + 5'd1;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_o <= 1'b0;
          done_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Registered read of C every cycle; out-of-range indices return zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_data_o <= '0;
    end else if (in_range(row_i, col_i)) begin
      rd_data_o <= c_m[idx(row_i, col_i)];
    end else begin
      rd_data_o <= '0;
    end
  end

endmodule

// File: tb/tb_tpu_ctrl.sv
// tb/tb_tpu_ctrl.sv - self-checking bench for tpu_ctrl
module tb_tpu_ctrl;
  localparam int DIM = 2;
  localparam int DW  = 32;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          wren_A_i = 1'b0, wren_B_i = 1'b0, wren_C_i = 1'b0, start_i = 1'b0;
  logic [4:0]    row_i = '0, col_i = '0;
  logic [DW-1:0] data_i = '0;
  logic [DW-1:0] rd_data_o;
  logic          busy_o, done_o, stall_o;

  int n_cmp = 0;
  int n_fail = 0;

  logic [31:0] ma [DIM][DIM];
  logic [31:0] mb [DIM][DIM];
  logic [31:0] mc [DIM][DIM];
  logic [31:0] got [DIM][DIM];

  tpu_ctrl #(.DIM(DIM), .DATA_W(DW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .wren_A_i(wren_A_i), .wren_B_i(wren_B_i), .wren_C_i(wren_C_i),
    .start_i(start_i), .row_i(row_i), .col_i(col_i), .data_i(data_i),
    .rd_data_o(rd_data_o), .busy_o(busy_o), .done_o(done_o), .stall_o(stall_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic model_clear();
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) begin
        ma[r][c] = '0; mb[r][c] = '0; mc[r][c] = '0;
      end
  endtask

  // C += A*B as plain matrix arithmetic, wrapping at 32 bits.
  task automatic model_mac();
    logic [31:0] p [DIM][DIM];
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) begin
        p[r][c] = '0;
        for (int t = 0; t < DIM; t++) p[r][c] = p[r][c] + ma[r][t] * mb[t][c];
      end
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) mc[r][c] = mc[r][c] + p[r][c];
  endtask

  task automatic wr(input logic wa, input logic wb, input logic wc,
                    input int r, input int c, input logic [31:0] d);
    wren_A_i = wa; wren_B_i = wb; wren_C_i = wc;
    row_i = 5'(r); col_i = 5'(c); data_i = d;
    @(posedge clk_i); #1;
    wren_A_i = 0; wren_B_i = 0; wren_C_i = 0;
    if (r < DIM && c < DIM) begin
      if (wa) ma[r][c] = d;
      if (wb) mb[r][c] = d;
      if (wc) mc[r][c] = d;
    end
  endtask

  task automatic rd(input int r, input int c, output logic [31:0] v);
    row_i = 5'(r); col_i = 5'(c);
    @(posedge clk_i); #1;
    v = rd_data_o;
  endtask

  task automatic read_all();
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) rd(r, c, got[r][c]);
  endtask

  task automatic load_all(input logic [31:0] a [DIM][DIM], input logic [31:0] b [DIM][DIM],
                          input logic [31:0] cc [DIM][DIM]);
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) begin
        wr(1, 0, 0, r, c, a[r][c]);
        wr(0, 1, 0, r, c, b[r][c]);
        wr(0, 0, 1, r, c, cc[r][c]);
      end
  endtask

  // Pulse start and count busy cycles until the operation ends.
  task automatic run_mac(output int nbusy, output int done_at, output int ndone);
    nbusy = 0; done_at = -1; ndone = 0;
    start_i = 1;
    @(posedge clk_i); #1;
    start_i = 0;
    while (busy_o && nbusy < 1000) begin
      nbusy++;
      if (done_o) begin done_at = nbusy; ndone++; end
      @(posedge clk_i); #1;
    end
    model_mac();
  endtask

  task automatic test_reset();
    logic [31:0] a [DIM][DIM], b [DIM][DIM], cc [DIM][DIM];
    #1;
    n_cmp++; if ({busy_o, done_o, stall_o} !== 3'b000 || rd_data_o !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got busy/done/stall=%b rd=%h, want 000 rd=0", {busy_o, done_o, stall_o}, rd_data_o); end
    @(posedge clk_i); #1; rst_i = 0;
    model_clear();
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) begin a[r][c] = 3; b[r][c] = 4; cc[r][c] = 7; end
    load_all(a, b, cc);
    start_i = 1; @(posedge clk_i); #1; start_i = 0;
    repeat (2) @(posedge clk_i);
    #1; wren_A_i = 1; rst_i = 1; #1;
    n_cmp++; if ({busy_o, done_o, stall_o} !== 3'b000) begin
      n_fail++; $display("FAIL reset_mid_mac: got busy/done/stall=%b, want 000", {busy_o, done_o, stall_o}); end
    wren_A_i = 0;
    @(posedge clk_i); #1; rst_i = 0;
    model_clear();
    read_all();
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) begin
        n_cmp++; if (got[r][c] !== 32'd0) begin
          n_fail++; $display("FAIL reset_c[%0d][%0d]: got %h, want 0", r, c, got[r][c]); end
      end
  endtask

  task automatic test_identity();
    logic [31:0] a [DIM][DIM] = '{'{1, 0}, '{0, 1}};
    logic [31:0] b [DIM][DIM] = '{'{5, 6}, '{7, 8}};
    logic [31:0] cc [DIM][DIM] = '{'{0, 0}, '{0, 0}};
    int nb, da, nd;
    load_all(a, b, cc);
    run_mac(nb, da, nd);
    n_cmp++; if (nb !== DIM*DIM*DIM+1 || da !== DIM*DIM*DIM+1 || nd !== 1) begin
      n_fail++; $display("FAIL identity_latency: got busy=%0d done_at=%0d ndone=%0d, want 9 9 1", nb, da, nd); end
    read_all();
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) begin
        n_cmp++; if (got[r][c] !== b[r][c] || got[r][c] !== mc[r][c]) begin
          n_fail++; $display("FAIL identity_c[%0d][%0d]: got %0d, want %0d", r, c, got[r][c], b[r][c]); end
      end
  endtask

  task automatic test_accumulate_wrap();
    logic [31:0] a [DIM][DIM] = '{'{1, 2}, '{3, 4}};
    logic [31:0] b [DIM][DIM] = '{'{5, 6}, '{7, 8}};
    logic [31:0] cc [DIM][DIM] = '{'{32'hFFFF_FFFF, 0}, '{0, 0}};
    logic [31:0] want [DIM][DIM] = '{'{32'h12, 22}, '{43, 50}};
    int nb, da, nd;
    load_all(a, b, cc);
    run_mac(nb, da, nd);
    read_all();
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) begin
        n_cmp++; if (got[r][c] !== want[r][c] || got[r][c] !== mc[r][c]) begin
          n_fail++; $display("FAIL wrap_c[%0d][%0d]: got %h, want %h", r, c, got[r][c], want[r][c]); end
      end
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) wr(0, 0, 1, r, c, 0);
    wr(1, 0, 0, 1, 0, 3);
    wr(1, 0, 0, 1, 1, 32'hFFFF_FFFF);
    run_mac(nb, da, nd);
    rd(1, 1, got[1][1]);
    n_cmp++; if (got[1][1] !== 32'd10 || got[1][1] !== mc[1][1]) begin
      n_fail++; $display("FAIL signed_c11: got %h, want 0000000a", got[1][1]); end
  endtask

  task automatic test_stall();
    logic [31:0] a [DIM][DIM], b [DIM][DIM], cc [DIM][DIM];
    int scnt, nb, da, nd;
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) begin
        a[r][c] = 32'($urandom_range(1, 100)); b[r][c] = 32'($urandom_range(1, 100)); cc[r][c] = 0;
      end
    load_all(a, b, cc);
    model_mac();
    start_i = 1; @(posedge clk_i); #1; start_i = 0;
    repeat (2) @(posedge clk_i);
    #1; wren_A_i = 1; row_i = 0; col_i = 0; data_i = 9; #1;
    scnt = 0;
    while (stall_o && scnt < 100) begin scnt++; @(posedge clk_i); #1; end
    n_cmp++; if (scnt !== DIM*DIM*DIM+1-2 || busy_o !== 1'b0) begin
      n_fail++; $display("FAIL stall_cycles: got %0d busy=%b, want %0d busy=0", scnt, busy_o, DIM*DIM*DIM-1); end
    @(posedge clk_i); #1; wren_A_i = 0;
    ma[0][0] = 9;
    read_all();
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) begin
        n_cmp++; if (got[r][c] !== mc[r][c]) begin
          n_fail++; $display("FAIL stall_result[%0d][%0d]: got %0d, want %0d", r, c, got[r][c], mc[r][c]); end
      end
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) begin
        wr(0, 1, 1, r, c, 0);
        if (r == c) wr(0, 1, 0, r, c, 1);
      end
    run_mac(nb, da, nd);
    rd(0, 0, got[0][0]);
    n_cmp++; if (got[0][0] !== 32'd9 || got[0][0] !== mc[0][0]) begin
      n_fail++; $display("FAIL stall_write_landed: got %0d, want 9", got[0][0]); end
  endtask

  task automatic test_boundary();
    logic [31:0] v, d;
    int nb, da, nd;
    d = $urandom;
    wr(1, 1, 1, 2, 0, d);
    wr(1, 1, 1, 0, 2, d);
    read_all();
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) begin
        n_cmp++; if (got[r][c] !== mc[r][c]) begin
          n_fail++; $display("FAIL oob_write_c[%0d][%0d]: got %h, want %h", r, c, got[r][c], mc[r][c]); end
      end
    rd(31, 0, v);
    n_cmp++; if (v !== 32'd0) begin n_fail++; $display("FAIL oob_read_row31: got %h, want 0", v); end
    rd(0, 31, v);
    n_cmp++; if (v !== 32'd0) begin n_fail++; $display("FAIL oob_read_col31: got %h, want 0", v); end
    d = 32'($urandom_range(2, 50));
    wren_A_i = 1; wren_B_i = 1; start_i = 1; row_i = 1; col_i = 1; data_i = d;
    @(posedge clk_i); #1;
    wren_A_i = 0; wren_B_i = 0; start_i = 0;
    ma[1][1] = d; mb[1][1] = d;
    nb = 0;
    while (busy_o && nb < 1000) begin nb++; @(posedge clk_i); #1; end
    model_mac();
    read_all();
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) begin
        n_cmp++; if (got[r][c] !== mc[r][c]) begin
          n_fail++; $display("FAIL write_start_c[%0d][%0d]: got %h, want %h", r, c, got[r][c], mc[r][c]); end
      end
    da = 0; nd = 0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] a [DIM][DIM], b [DIM][DIM], cc [DIM][DIM];
    int nb;
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) begin
        a[r][c] = $urandom; b[r][c] = $urandom; cc[r][c] = $urandom;
      end
    load_all(a, b, cc);
    start_i = 1; @(posedge clk_i); #1; start_i = 0;
    nb = 0;
    while (!done_o && nb < 1000) begin nb++; @(posedge clk_i); #1; end
    start_i = 1; #1;
    n_cmp++; if (stall_o !== 1'b1 || done_o !== 1'b1) begin
      n_fail++; $display("FAIL b2b_stall_done: got stall=%b done=%b, want 1 1", stall_o, done_o); end
    @(posedge clk_i); #1;
    n_cmp++; if (busy_o !== 1'b0 || stall_o !== 1'b0) begin
      n_fail++; $display("FAIL b2b_idle_gap: got busy=%b stall=%b, want 0 0", busy_o, stall_o); end
    @(posedge clk_i); #1; start_i = 0;
    n_cmp++; if (busy_o !== 1'b1) begin
      n_fail++; $display("FAIL b2b_restart: got busy=%b, want 1", busy_o); end
    nb = 0;
    while (busy_o && nb < 1000) begin nb++; @(posedge clk_i); #1; end
    model_mac(); model_mac();
    read_all();
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) begin
        n_cmp++; if (got[r][c] !== mc[r][c]) begin
          n_fail++; $display("FAIL b2b_c[%0d][%0d]: got %h, want %h", r, c, got[r][c], mc[r][c]); end
      end
  endtask

  task automatic test_random();
    logic [31:0] a [DIM][DIM], b [DIM][DIM], cc [DIM][DIM];
    int nb, da, nd;
    for (int round = 0; round < 3; round++) begin
      for (int r = 0; r < DIM; r++)
        for (int c = 0; c < DIM; c++) begin
          a[r][c] = $urandom; b[r][c] = $urandom; cc[r][c] = $urandom;
        end
      load_all(a, b, cc);
      run_mac(nb, da, nd);
      read_all();
      for (int r = 0; r < DIM; r++)
        for (int c = 0; c < DIM; c++) begin
          n_cmp++; if (got[r][c] !== mc[r][c]) begin
            n_fail++; $display("FAIL random%0d_c[%0d][%0d]: got %h, want %h", round, r, c, got[r][c], mc[r][c]); end
        end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_identity();
    test_accumulate_wrap();
    test_stall();
    test_boundary();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
